// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares the single-port data memory between the pipeline MEM stage (CPU)
// and the filter-sample DMA loader. One access per cycle; the CPU has
// default priority. The DMA is granted after MAX_WAIT consecutive denied
// cycles, and it keeps ownership for a burst of up to MAX_BURST beats.
// Read data comes back one cycle later and is steered to whichever side
// issued the read.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cpu_re/we/addr/wdata       CPU load/store request (held until granted)
//   cpu_stall                  CPU request not granted this cycle
//   cpu_rvalid/rdata           CPU load data return
//   dma_req/we/addr/wdata/last DMA beat request (held until granted)
//   dma_gnt                    DMA beat consumed this cycle
//   dma_rvalid/rdata           DMA read data return
//   mem_re/we/addr/wdata       memory strobes (mux of the granted requester)
//   mem_rdata                  memory read data, valid 1 cycle after mem_re
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 16,
    parameter int MAX_WAIT  = 4,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_re,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    input  logic          dma_last,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_re,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    typedef enum logic {CPU_PRI, DMA_BURST} state_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_CPU, GNT_DMA} gnt_t;

    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic [BW-1:0] burst_cnt;
    logic          rd_pend;     // a granted read is returning this cycle
    logic          rd_dma;      // owner tag of that read: 1 = DMA, 0 = CPU

    logic          cpu_acc;
    gnt_t          gnt;
    logic          rd_issue;
    logic [BW-1:0] burst_nxt;

    assign cpu_acc   = cpu_re | cpu_we;
    assign burst_nxt = burst_cnt + 1'b1;

    // Grant decision and memory mux, purely from registered state and the
    // requests presented this cycle.
    // NOTE: every signal driven here gets a default first so no path through
    // the case statement leaves one unassigned, which would infer a latch.
    always_comb begin
        gnt = GNT_NONE;
        unique case (state)
            CPU_PRI: begin
                // Once the DMA has been denied MAX_WAIT times in a row, the
                // CPU branch is closed and the DMA takes the port.
                if (cpu_acc && (wait_cnt < WAIT_MAX)) gnt = GNT_CPU;
                else if (dma_req)                     gnt = GNT_DMA;
            end
            DMA_BURST: begin
                if (dma_req)      gnt = GNT_DMA;
                else if (cpu_acc) gnt = GNT_CPU;
            end
            default: gnt = GNT_NONE;
        endcase

        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt == GNT_CPU) begin
            mem_we    = cpu_we;
            mem_re    = cpu_re & ~cpu_we;   // a simultaneous re/we is a store
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (gnt == GNT_DMA) begin
            mem_we    = dma_we;
            mem_re    = ~dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    assign cpu_stall = cpu_acc & (gnt != GNT_CPU);
    assign dma_gnt   = (gnt == GNT_DMA);
    assign rd_issue  = mem_re;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CPU_PRI;
            wait_cnt  <= '0;
            burst_cnt <= '0;
            rd_pend   <= 1'b0;
            rd_dma    <= 1'b0;
        end else begin
            rd_pend <= rd_issue;
            rd_dma  <= rd_issue & (gnt == GNT_DMA);

            unique case (state)
                CPU_PRI: begin
                    if (gnt == GNT_CPU) begin
                        // CPU branch is only open below WAIT_MAX, so this
                        // increment saturates at WAIT_MAX and never wraps.
                        if (dma_req) wait_cnt <= wait_cnt + 1'b1;
                    end else if (gnt == GNT_DMA) begin
                        wait_cnt <= '0;
                        if (!dma_last && (MAX_BURST > 1)) begin
                            state     <= DMA_BURST;
                            burst_cnt <= BW'(1);
                        end else begin
                            burst_cnt <= '0;
                        end
                    end
                end
                DMA_BURST: begin
                    if (gnt == GNT_DMA && !(dma_last || burst_nxt == BURST_MAX)) begin
                        burst_cnt <= burst_nxt;
                    end else begin
                        // Last beat, burst cap reached, or burst abandoned.
                        state     <= CPU_PRI;
                        burst_cnt <= '0;
                    end
                end
                default: state <= CPU_PRI;
            endcase
        end
    end

    // Read return: the owner sees mem_rdata, everyone else sees zero.
    assign cpu_rvalid = rd_pend & ~rd_dma;
    assign dma_rvalid = rd_pend &  rd_dma;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dma_rdata  = dma_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_port_arbiter
//
// Directed scenarios followed by constrained-random traffic. A reference
// model (arbitration rules as integer counters plus a shadow memory) predicts
// every output each cycle; a behavioural memory answers the DUT's strobes.
// ---------------------------------------------------------------------------
module tb_dmem_port_arbiter;

    localparam int AW        = 8;
    localparam int DW        = 16;
    localparam int MAX_WAIT  = 4;
    localparam int MAX_BURST = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_re, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          dma_req, dma_we, dma_last;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_gnt, dma_rvalid;
    logic [DW-1:0] dma_rdata;
    logic          mem_re, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    dmem_port_arbiter #(
        .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_last(dma_last), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Initial memory contents: a fixed pattern with 0xBEEF planted at 0x10.
    function automatic logic [DW-1:0] seed(input logic [AW-1:0] a);
        if (a == 8'h10) return 16'hBEEF;
        return {a, ~a} ^ 16'h5A3C;
    endfunction

    // Behavioural single-port memory, one-cycle read latency.
    logic [DW-1:0] mem [256];
    logic [255:0]  mem_written = '0;
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr]         <= mem_wdata;
            mem_written[mem_addr] <= 1'b1;
        end
        if (mem_re) mem_rdata <= mem_written[mem_addr] ? mem[mem_addr] : seed(mem_addr);
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // who: 0 none, 1 cpu, 2 dma
    int            m_who;
    bit            m_dma_owns;    // DMA currently holds burst ownership
    int            m_denied;      // consecutive cycles the DMA asked and lost
    int            m_beats;       // beats consumed in the current ownership
    bit            m_rd_pend;
    bit            m_rd_dma;
    logic [DW-1:0] m_rd_data;
    logic [DW-1:0] shadow [256];

    // Last observed values, for directed checks.
    logic o_stall, o_gnt, o_mem_re, o_mem_we;
    logic [DW-1:0] o_mem_wdata;

    task automatic model_reset();
        m_dma_owns = 0; m_denied = 0; m_beats = 0;
        m_rd_pend = 0; m_rd_dma = 0; m_rd_data = '0;
    endtask

    task automatic predict();
        bit acc;
        acc = cpu_re | cpu_we;
        m_who = 0;
        if (m_dma_owns)                      m_who = dma_req ? 2 : (acc ? 1 : 0);
        else if (acc && m_denied < MAX_WAIT) m_who = 1;
        else if (dma_req)                    m_who = 2;
    endtask

    task automatic check_all();
        bit acc, e_re, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        acc = cpu_re | cpu_we;
        e_re = 0; e_we = 0; e_addr = '0; e_wd = '0;
        if (m_who == 1) begin
            e_we = cpu_we; e_re = cpu_re && !cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata;
        end else if (m_who == 2) begin
            e_we = dma_we; e_re = !dma_we; e_addr = dma_addr; e_wd = dma_wdata;
        end
        check("cpu_stall",  32'(cpu_stall),  32'(acc && m_who != 1));
        check("dma_gnt",    32'(dma_gnt),    32'(m_who == 2));
        check("mem_re",     32'(mem_re),     32'(e_re));
        check("mem_we",     32'(mem_we),     32'(e_we));
        check("mem_addr",   32'(mem_addr),   32'(e_addr));
        check("mem_wdata",  32'(mem_wdata),  32'(e_wd));
        check("cpu_rvalid", 32'(cpu_rvalid), 32'(m_rd_pend && !m_rd_dma));
        check("cpu_rdata",  32'(cpu_rdata),  32'((m_rd_pend && !m_rd_dma) ? m_rd_data : '0));
        check("dma_rvalid", 32'(dma_rvalid), 32'(m_rd_pend && m_rd_dma));
        check("dma_rdata",  32'(dma_rdata),  32'((m_rd_pend && m_rd_dma) ? m_rd_data : '0));
    endtask

    task automatic model_advance();
        bit rd, wr;
        logic [AW-1:0] a;
        rd = 0; wr = 0; a = '0;
        if (m_who == 1) begin wr = cpu_we; rd = cpu_re && !cpu_we; a = cpu_addr; end
        if (m_who == 2) begin wr = dma_we; rd = !dma_we;           a = dma_addr; end
        m_rd_pend = rd;
        m_rd_dma  = rd && (m_who == 2);
        m_rd_data = shadow[a];
        if (wr) shadow[a] = (m_who == 1) ? cpu_wdata : dma_wdata;

        if (!m_dma_owns) begin
            if (m_who == 1 && dma_req) m_denied = (m_denied + 1 > MAX_WAIT) ? MAX_WAIT : m_denied + 1;
            if (m_who == 2) begin
                m_denied = 0;
                m_beats  = 1;
                m_dma_owns = !dma_last && (m_beats < MAX_BURST);
                if (!m_dma_owns) m_beats = 0;
            end
        end else if (m_who == 2) begin
            m_beats++;
            if (dma_last || m_beats == MAX_BURST) begin m_dma_owns = 0; m_beats = 0; end
        end else begin
            m_dma_owns = 0; m_beats = 0;
        end
    endtask

    // One clock cycle: check at the falling edge, advance the model at the
    // rising edge, return 1 time unit later ready for new stimulus.
    task automatic step();
        @(negedge clk);
        predict();
        check_all();
        o_stall = cpu_stall; o_gnt = dma_gnt; o_mem_re = mem_re; o_mem_we = mem_we;
        o_mem_wdata = mem_wdata;
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic idle_inputs();
        cpu_re = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0; dma_last = 0;
    endtask

    initial begin
        int beats, run, max_run;
        for (int i = 0; i < 256; i++) shadow[i] = seed(AW'(i));

        // ---- reset state ----
        idle_inputs();
        rst_n = 0;
        model_reset();
        #12;
        predict();
        check_all();
        @(posedge clk); #1;
        rst_n = 1;

        // ---- CPU read only ----
        cpu_re = 1; cpu_addr = 8'h10;
        step();
        check("rd_mem_re", 32'(o_mem_re), 32'd1);
        check("rd_stall0", 32'(o_stall), 32'd0);
        cpu_re = 0;
        check("rd_rvalid", 32'(cpu_rvalid), 32'd1);
        check("rd_rdata",  32'(cpu_rdata),  32'hBEEF);
        step();

        // ---- conflict + starvation ----
        cpu_re = 1; cpu_addr = 8'h11;
        dma_req = 1; dma_we = 0; dma_addr = 8'h30; dma_last = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("starve_stall_c%0d", i), 32'(o_stall), 32'(i == 4));
            check($sformatf("starve_gnt_c%0d", i),   32'(o_gnt),   32'(i == 4));
        end
        idle_inputs();
        step();
        step();

        // ---- DMA burst, CPU idle: write 0x20, write 0x21, read 0x22 last ----
        for (int i = 0; i < 3; i++) begin
            dma_req = 1; dma_we = (i < 2); dma_addr = AW'(8'h20 + i);
            dma_wdata = 16'hA000 + 16'(i); dma_last = (i == 2);
            step();
            check($sformatf("burst3_gnt%0d", i), 32'(o_gnt), 32'd1);
        end
        idle_inputs();
        check("burst3_rvalid", 32'(dma_rvalid), 32'd1);
        step();
        // Back in CPU priority: a lone CPU access goes straight through.
        cpu_we = 1; cpu_addr = 8'h60; cpu_wdata = 16'h0F0F;
        step();
        check("burst3_cpu_after", 32'(o_stall), 32'd0);
        idle_inputs();

        // ---- burst cap: 10-beat DMA burst, CPU storing throughout ----
        beats = 0; run = 0; max_run = 0;
        for (int c = 0; c < 60 && beats < 10; c++) begin
            cpu_we = 1; cpu_addr = AW'(8'h70 + c); cpu_wdata = 16'(c);
            dma_req = 1; dma_we = 1; dma_addr = AW'(8'h40 + beats);
            dma_wdata = 16'hD000 + 16'(beats); dma_last = (beats == 9);
            step();
            if (o_gnt) begin
                beats++; run++;
                if (run > max_run) max_run = run;
            end else run = 0;
        end
        check("cap_beats",   32'(beats),   32'd10);
        check("cap_max_run", 32'(max_run), 32'(MAX_BURST));
        idle_inputs();
        step();

        // ---- simultaneous cpu_re and cpu_we ----
        cpu_re = 1; cpu_we = 1; cpu_addr = 8'h05; cpu_wdata = 16'h1234;
        step();
        check("rw_mem_we",    32'(o_mem_we),    32'd1);
        check("rw_mem_re",    32'(o_mem_re),    32'd0);
        check("rw_mem_wdata", 32'(o_mem_wdata), 32'h1234);
        idle_inputs();
        check("rw_no_rvalid", 32'(cpu_rvalid), 32'd0);
        step();

        // ---- reset mid-read ----
        dma_req = 1; dma_we = 0; dma_addr = 8'h22; dma_last = 1;
        step();
        check("rst_rd_granted", 32'(o_gnt), 32'd1);
        idle_inputs();
        rst_n = 0;
        model_reset();
        #1;
        check("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        cpu_re = 1; cpu_addr = 8'h05;
        step();
        check("rst_cpu_stall", 32'(o_stall),  32'd0);
        check("rst_cpu_re",    32'(o_mem_re), 32'd1);
        cpu_re = 0;
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'h1234);
        step();

        // ---- randomized traffic; requests held while not granted ----
        for (int c = 0; c < 400; c++) begin
            if (!((cpu_re | cpu_we) && m_who != 1)) begin
                cpu_re = ($urandom_range(0, 2) == 0);
                cpu_we = ($urandom_range(0, 3) == 0);
                cpu_addr = AW'($urandom_range(0, 31));
                cpu_wdata = DW'($urandom);
            end
            if (!(dma_req && m_who != 2)) begin
                dma_req = ($urandom_range(0, 1) == 0);
                dma_we  = $urandom_range(0, 1) != 0;
                dma_addr = AW'($urandom_range(0, 31));
                dma_wdata = DW'($urandom);
                dma_last = ($urandom_range(0, 4) == 0);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
